irq_pending_arbiter: RTL

IRQ_PENDING_ARBITER -- requirements
Module: irq_pending_arbiter

---
 rtl/irq_pending_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: captures interrupt request events into a pending vector
// and offers the highest-priority eligible channel over a valid/ready handshake.
//
// Ports:
//   clk_i        - single clock, all state updates on the rising edge
//   rst_n_i      - asynchronous active-low reset
//   req_i[7:0]   - request lines (bit 7 highest priority)
//   mask_i[7:0]  - 1 = channel excluded from arbitration (still captured)
//   en_i         - arbitration enable
//   irq_valid_o  - a granted channel id is offered
//   irq_id_o     - offered channel index
//   irq_ready_i  - consumer accepts the offer
//   pending_o    - registered pending vector
//   overflow_o   - sticky lost-event flag (edge mode only)
//   clear_ovf_i  - clears overflow_o
module irq_pending_arbiter #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] req_i,
    input  logic [7:0] mask_i,
    input  logic       en_i,
    output logic       irq_valid_o,
    output logic [2:0] irq_id_o,
    input  logic       irq_ready_i,
    output logic [7:0] pending_o,
    output logic       overflow_o,
    input  logic       clear_ovf_i
);

    typedef enum logic [0:0] {StIdle = 1'b0, StOffer = 1'b1} state_e;

    state_e     r_state;
    state_e     w_state_d;
    logic [2:0] r_id;
    logic [2:0] w_id_d;
    logic [7:0] r_pending;
    logic [7:0] w_pending_d;
    logic [7:0] r_req_q;
    logic       r_ovf;
    logic       w_ovf_d;

    logic [7:0] w_set_evt;
    logic       w_accept;
    logic [7:0] w_clr;
    logic [7:0] w_eligible;
    logic       w_grant;
    logic [2:0] w_id_sel;
    logic       w_ovf_evt;

    // Event detection and pending bookkeeping
    assign w_set_evt  = EDGE_MODE ? (req_i & ~r_req_q) : req_i;
    assign w_accept   = (r_state == StOffer) && irq_ready_i;
    assign w_clr      = w_accept ? (8'h01 << r_id) : 8'h00;
    // Set wins over a same-cycle acceptance clear
    assign w_pending_d = (r_pending & ~w_clr) | w_set_evt;
    // A new event on a channel still pending (and not leaving) is a lost event
    assign w_ovf_evt  = EDGE_MODE && (|(w_set_evt & r_pending & ~w_clr));
    assign w_ovf_d    = w_ovf_evt | (r_ovf & ~clear_ovf_i);

    assign w_eligible = r_pending & ~mask_i;
    assign w_grant    = en_i && (|w_eligible);

    // Priority encoder: later iterations overwrite, so the highest set bit wins
    always_comb begin
        w_id_sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_eligible[i]) begin
                w_id_sel = 3'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= StIdle;
            r_id      <= 3'd0;
            r_pending <= 8'h00;
            r_req_q   <= 8'h00;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_id      <= w_id_d;
            r_pending <= w_pending_d;
            r_req_q   <= req_i;
            r_ovf     <= w_ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_grant) w_state_d = StOffer;
            StOffer: if (irq_ready_i) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Output logic: id is latched only when leaving IDLE, held through OFFER
    always_comb begin
        w_id_d = r_id;
        if ((r_state == StIdle) && w_grant) begin
            w_id_d = w_id_sel;
        end
    end

    assign irq_valid_o = (r_state == StOffer);
    assign irq_id_o    = r_id;
    assign pending_o   = r_pending;
    assign overflow_o  = r_ovf;

endmodule
